// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I instruction assembler.
// Packs field requests (format, opcode[6:2], registers, immediate) into 32-bit
// instruction words tagged with sequential instruction-memory byte addresses.
// Illegal requests (bad format or out-of-range immediate) emit a NOP with out_err.
// One registered stage, valid/ready on both sides, full throughput.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   restart               next address back to BASE_ADDR, clears err_cnt
//   in_valid/in_ready     request handshake (in_ready is combinational)
//   in_fmt..in_imm        request fields (fmt 0=R 1=I 2=S 3=B 4=U 5=J)
//   out_valid/out_ready   word handshake
//   out_inst/out_addr     encoded word and its byte address
//   out_err               word is a NOP substituted for an illegal request
//   err_cnt               saturating count of error words transferred
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [4:0]           in_opc,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned WORD_W   = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [WORD_W-1:0] ADDR_STEP = 32'd4;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [WORD_W-1:0]    out_inst_q, out_inst_d;
  logic [WORD_W-1:0]    out_addr_q, out_addr_d;
  logic [WORD_W-1:0]    next_addr_q, next_addr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WORD_W-1:0]    enc_inst;
  logic                 enc_legal;
  logic [6:0]           opcode;
  logic                 accept;
  logic                 xfer;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign opcode   = {in_opc, 2'b11};

  // Field packing and immediate range checks. A signed range [-2^k, 2^k-1]
  // holds exactly when imm[31:k] is all zeros or all ones.
  always_comb begin
    enc_inst  = NOP_WORD;
    enc_legal = 1'b0;
    unique case (in_fmt)
      FMT_R: begin
        enc_legal = 1'b1;
        enc_inst  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opcode};
      end
      FMT_I: begin
        enc_legal = (&in_imm[31:11]) || (~|in_imm[31:11]);
        enc_inst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, opcode};
      end
      FMT_S: begin
        enc_legal = (&in_imm[31:11]) || (~|in_imm[31:11]);
        enc_inst  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opcode};
      end
      FMT_B: begin
        enc_legal = ((&in_imm[31:12]) || (~|in_imm[31:12])) && !in_imm[0];
        enc_inst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], opcode};
      end
      FMT_U: begin
        enc_legal = ~|in_imm[11:0];
        enc_inst  = {in_imm[31:12], in_rd, opcode};
      end
      FMT_J: begin
        enc_legal = ((&in_imm[31:20]) || (~|in_imm[31:20])) && !in_imm[0];
        enc_inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
      end
      default: begin
        enc_legal = 1'b0;
        enc_inst  = NOP_WORD;
      end
    endcase
    if (!enc_legal) enc_inst = NOP_WORD;
  end

  // Output stage, address sequencing and error counter next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    next_addr_d = next_addr_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_err_d   = !enc_legal;
      out_addr_d  = restart ? BASE_ADDR : next_addr_q;
      next_addr_d = out_addr_d + ADDR_STEP;
    end else begin
      if (xfer)    out_valid_d = 1'b0;
      if (restart) next_addr_d = BASE_ADDR;
    end

    // restart takes priority over counting a transferred error word
    if (restart) begin
      err_cnt_d = '0;
    end else if (xfer && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      next_addr_q <= BASE_ADDR;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      next_addr_q <= next_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: the driver pushes the expected word and
// address when a request is accepted; an independent monitor pops and compares
// on every output transfer and checks held outputs stay stable under stall.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_opc;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst, out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  inst_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opc(in_opc), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [31:0] model_next;

  // monitor-owned state
  bit          hv = 0;
  logic [31:0] h_inst, h_addr;
  logic        h_err;
  int          ecnt = 0;

  int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098, 4093,
                  -1048576, 1048574, 1048576, -1048578, 1048573};

  always @(posedge clk) cyc <= cyc + 1;

  // consumer back-pressure: 0 always ready, 1 random, 2 stalled
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(logic [31:0] x, int hi, int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference: instruction bit positions assembled arithmetically, legality by
  // signed integer comparison. Returns {err, inst}.
  function automatic logic [32:0] model(req_t r);
    int          si;
    logic [31:0] o, w;
    bit          ok;
    si = $signed(r.imm);
    o  = 32'(r.opc) * 4 + 3;
    w  = 32'h13;
    ok = 1'b0;
    case (r.fmt)
      3'd0: begin ok = 1;
        w = (32'(r.f7) << 25) + (32'(r.rs2) << 20) + (32'(r.rs1) << 15)
          + (32'(r.f3) << 12) + (32'(r.rd) << 7) + o; end
      3'd1: begin ok = (si >= -2048) && (si <= 2047);
        w = (fld(r.imm, 11, 0) << 20) + (32'(r.rs1) << 15) + (32'(r.f3) << 12)
          + (32'(r.rd) << 7) + o; end
      3'd2: begin ok = (si >= -2048) && (si <= 2047);
        w = (fld(r.imm, 11, 5) << 25) + (32'(r.rs2) << 20) + (32'(r.rs1) << 15)
          + (32'(r.f3) << 12) + (fld(r.imm, 4, 0) << 7) + o; end
      3'd3: begin ok = (si >= -4096) && (si <= 4094) && (si % 2 == 0);
        w = (fld(r.imm, 12, 12) << 31) + (fld(r.imm, 10, 5) << 25) + (32'(r.rs2) << 20)
          + (32'(r.rs1) << 15) + (32'(r.f3) << 12) + (fld(r.imm, 4, 1) << 8)
          + (fld(r.imm, 11, 11) << 7) + o; end
      3'd4: begin ok = (r.imm % 4096 == 0);
        w = r.imm - (r.imm % 4096) + (32'(r.rd) << 7) + o; end
      3'd5: begin ok = (si >= -1048576) && (si <= 1048574) && (si % 2 == 0);
        w = (fld(r.imm, 20, 20) << 31) + (fld(r.imm, 10, 1) << 21) + (fld(r.imm, 11, 11) << 20)
          + (fld(r.imm, 19, 12) << 12) + (32'(r.rd) << 7) + o; end
      default: ok = 0;
    endcase
    if (!ok) w = 32'h13;
    return {!ok, w};
  endfunction

  function automatic req_t mk(int fmt, int opc, int f3, int f7, int rd, int rs1, int rs2, int imm);
    req_t r;
    r.fmt = 3'(fmt); r.opc = 5'(opc); r.f3 = 3'(f3); r.f7 = 7'(f7);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 32'(imm);
    return r;
  endfunction

  task automatic send_exp(req_t r, logic [31:0] ei, logic ee);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    in_fmt = r.fmt; in_opc = r.opc; in_funct3 = r.f3; in_funct7 = r.f7;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.inst = ei; e.err = ee;
        e.addr = restart ? BASE : model_next;
        model_next = e.addr + 32'd4;
        sb.push_back(e);
        done = 1;
      end else if (restart) begin
        model_next = BASE;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 1000) begin
        total++; bad++;
        $display("FAIL accept_timeout: got in_ready=0 want 1 within 1000 cycles");
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send(req_t r);
    logic [32:0] m;
    m = model(r);
    send_exp(r, m[31:0], m[32]);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    model_next = BASE;
  endtask

  // monitor: compares every transfer and checks stalled outputs hold
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 0; ecnt = 0;
      end else begin
        chk("err_cnt", 32'(err_cnt), 32'(ecnt));
        if (hv) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_inst", out_inst, h_inst);
          chk("hold_addr", out_addr, h_addr);
          chk("hold_err", 32'(out_err), 32'(h_err));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got inst %h addr %h want none", out_inst, out_addr);
          end else begin
            e = sb.pop_front();
            chk("inst", out_inst, e.inst);
            chk("addr", out_addr, e.addr);
            chk("err", 32'(out_err), 32'(e.err));
            if (e.err && ecnt < 255) ecnt++;
          end
        end
        hv = out_valid && !out_ready;
        h_inst = out_inst; h_addr = out_addr; h_err = out_err;
        if (restart) ecnt = 0;
      end
    end
  end

  initial begin
    req_t r;
    int   c0;
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opc = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    model_next = BASE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: I-type, one-cycle latency
    send_exp(mk(1, 5'b00100, 0, 0, 1, 0, 0, 5), 32'h0050_0093, 1'b0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_inst", out_inst, 32'h0050_0093);

    // 2: S then B back to back
    c0 = cyc;
    send_exp(mk(2, 5'b01000, 3'b010, 0, 0, 1, 2, 8), 32'h0020_A423, 1'b0);
    send_exp(mk(3, 5'b11000, 0, 0, 0, 0, 0, -8), 32'hFE00_0CE3, 1'b0);
    chk("b2b_cycles", 32'(cyc - c0), 32'd2);

    // 3: J and U
    send_exp(mk(5, 5'b11011, 0, 0, 1, 0, 0, 2048), 32'h0010_00EF, 1'b0);
    send_exp(mk(4, 5'b01101, 0, 0, 5, 0, 0, 32'h1234_5000), 32'h1234_52B7, 1'b0);
    drain();

    // 4: three illegal requests
    restart_pulse();
    send_exp(mk(1, 5'b00100, 0, 0, 1, 0, 0, 2048), 32'h0000_0013, 1'b1);
    send_exp(mk(3, 5'b11000, 0, 0, 0, 0, 0, 3), 32'h0000_0013, 1'b1);
    send_exp(mk(7, 5'b00100, 0, 0, 1, 0, 0, 0), 32'h0000_0013, 1'b1);
    drain();
    chk("errcnt_3", 32'(err_cnt), 32'd3);

    // 5: consumer stall with a pending request
    rdy_mode = 2;
    send(mk(0, 5'b01100, 3'd0, 7'h20, 3, 4, 5, 0));
    fork
      send(mk(1, 5'b00100, 3'd7, 0, 6, 7, 0, -1));
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    wait fork;
    drain();

    // random traffic with back-pressure, gaps and occasional restart
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0);
      case ($urandom_range(0, 3))
        0: r.imm = $urandom;
        1: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: r.imm = 32'(bnd[$urandom_range(0, 13)]);
        default: r.imm = $urandom & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 29) == 0) restart = 1'b1;
      send(r);
      restart = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    drain();

    // 6: reset with a held word, then restart
    rdy_mode = 2;
    send(mk(1, 5'b00100, 0, 0, 2, 3, 0, 100));
    chk("held_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", out_addr, 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    chk("arst_errcnt", 32'(err_cnt), 32'd0);
    sb.delete();
    model_next = BASE;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    send(mk(1, 5'b00100, 0, 0, 1, 0, 0, 5));
    send(mk(6, 0, 0, 0, 0, 0, 0, 0));
    drain();
    chk("errcnt_1", 32'(err_cnt), 32'd1);
    restart_pulse();
    chk("restart_errcnt", 32'(err_cnt), 32'd0);
    send(mk(5, 5'b11011, 0, 0, 1, 0, 0, -2));
    drain();
    chk("restart_addr", out_addr, BASE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
